// File: rtl/sha3_absorb_ctrl.sv
// SHA-3 absorb sequencer: drains 64-bit message words from the FIFO into the rate lanes,
// applies 0x06...0x80 padding and launches one permutation per rate block.
module sha3_absorb_ctrl #(
    parameter int WIDTH      = 64,
    parameter int RATE_LANES = 17,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] msg_words_i,
    input  logic [3:0]       last_valid_i,
    input  logic [WIDTH-1:0] fifo_out_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    output logic             lane_we_o,
    output logic [4:0]       lane_idx_o,
    output logic [WIDTH-1:0] lane_data_o,
    output logic             perm_start_o,
    input  logic             perm_done_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int              BYTES     = WIDTH / 8;
    localparam logic [4:0]      LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [WIDTH-1:0] PAD_LO   = {{(WIDTH-8){1'b0}}, 8'h06};
    localparam logic [WIDTH-1:0] END_HI   = {8'h80, {(WIDTH-8){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PAD,
        S_FINAL,
        S_PERM,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic [3:0]       lastv_q, lastv_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d;
    logic [4:0]       lane_q, lane_d;
    logic             fin_q, fin_d;
    logic             perm_first_q, perm_first_d;

    logic [WIDTH-1:0] keep_mask;
    logic [WIDTH-1:0] pad_bits;
    logic [LEN_W:0]   wcnt_inc;
    logic             last_word;
    logic             partial;
    logic             at_last_lane;

    // Byte k of the final word survives if k < last_valid; the 0x06 domain byte lands at k == last_valid.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_byte
            assign keep_mask[gi*8 +: 8] = (lastv_q > 4'(gi)) ? 8'hFF : 8'h00;
            assign pad_bits[gi*8 +: 8]  = (lastv_q == 4'(gi)) ? 8'h06 : 8'h00;
        end
    endgenerate

    assign wcnt_inc     = {1'b0, wcnt_q} + (LEN_W+1)'(1);
    assign last_word    = (wcnt_inc == {1'b0, words_q});
    assign partial      = (lastv_q < 4'd8);
    assign at_last_lane = (lane_q == LAST_LANE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            words_q      <= '0;
            lastv_q      <= '0;
            wcnt_q       <= '0;
            lane_q       <= '0;
            fin_q        <= 1'b0;
            perm_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_q      <= words_d;
            lastv_q      <= lastv_d;
            wcnt_q       <= wcnt_d;
            lane_q       <= lane_d;
            fin_q        <= fin_d;
            perm_first_q <= perm_first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        lastv_d     = lastv_q;
        wcnt_d      = wcnt_q;
        lane_d      = lane_q;
        fin_d       = fin_q;
        fifo_rd_o   = 1'b0;
        lane_we_o   = 1'b0;
        lane_idx_o  = '0;
        lane_data_o = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    words_d = msg_words_i;
                    lastv_d = last_valid_i;
                    wcnt_d  = '0;
                    lane_d  = '0;
                    fin_d   = 1'b0;
                    state_d = (msg_words_i != '0) ? S_FETCH : S_PAD;
                end
            end

            S_FETCH: begin
                fifo_rd_o = !fifo_empty_i;
                if (!fifo_empty_i) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                lane_we_o   = 1'b1;
                lane_idx_o  = lane_q;
                lane_data_o = fifo_out_i;
                if (last_word && partial) begin
                    lane_data_o = (fifo_out_i & keep_mask) | pad_bits | (at_last_lane ? END_HI : '0);
                end
                wcnt_d = wcnt_inc[LEN_W-1:0];
                if (at_last_lane) begin
                    fin_d   = last_word && partial;
                    state_d = S_PERM;
                end else begin
                    lane_d = lane_q + 5'd1;
                    if (!last_word) begin
                        state_d = S_FETCH;
                    end else if (partial) begin
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_PAD;
                    end
                end
            end

            // Message ended on a word boundary: the domain byte gets a lane of its own.
            S_PAD: begin
                lane_we_o   = 1'b1;
                lane_idx_o  = lane_q;
                lane_data_o = PAD_LO | (at_last_lane ? END_HI : '0);
                if (at_last_lane) begin
                    fin_d   = 1'b1;
                    state_d = S_PERM;
                end else begin
                    lane_d  = lane_q + 5'd1;
                    state_d = S_FINAL;
                end
            end

            S_FINAL: begin
                lane_we_o   = 1'b1;
                lane_idx_o  = LAST_LANE;
                lane_data_o = END_HI;
                fin_d       = 1'b1;
                state_d     = S_PERM;
            end

            S_PERM: begin
                if (perm_done_i) begin
                    lane_d = '0;
                    if (fin_q) begin
                        state_d = S_DONE;
                    end else if (wcnt_q != words_q) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_PAD;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // perm_start is a registered one-shot marking the first cycle spent in PERM.
    assign perm_first_d = (state_d == S_PERM) && (state_q != S_PERM);
    assign perm_start_o = perm_first_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Bench for sha3_absorb_ctrl: byte-stream padding model produces the expected lane writes,
// permutations and done pulse; directed cases pin literal values, then randomized messages.
module tb_sha3_absorb_ctrl;

    localparam int RL = 17;
    localparam int RB = RL * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] msg_words = '0;
    logic [3:0]  last_valid = '0;
    logic [63:0] fifo_out = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd;
    logic        lane_we;
    logic [4:0]  lane_idx;
    logic [63:0] lane_data;
    logic        perm_start;
    logic        perm_done = 1'b0;
    logic        busy;
    logic        done;

    sha3_absorb_ctrl #(.WIDTH(64), .RATE_LANES(RL), .LEN_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .msg_words_i  (msg_words),
        .last_valid_i (last_valid),
        .fifo_out_i   (fifo_out),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_o    (fifo_rd),
        .lane_we_o    (lane_we),
        .lane_idx_o   (lane_idx),
        .lane_data_o  (lane_data),
        .perm_start_o (perm_start),
        .perm_done_i  (perm_done),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 lane write, 1 perm_start, 2 done
        int          idx;
        logic [63:0] data;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         log_q[$];
    logic [63:0] fifo_q[$];
    logic [63:0] words_a [0:63];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_we = -1;
    int t_start = 0;
    int perm_cnt = 0;
    int rd_cnt = 0;
    int perm_delay = 0;
    int hold_cnt = 0;
    bit rd_req = 1'b0;
    bit rand_empty = 1'b0;
    bit spur_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: pad the message as a byte string, cut it into rate blocks, and list the
    // lanes the sequencer must touch (all lanes of full blocks; in the last block the lanes
    // up to the one holding 0x06, plus the top lane carrying 0x80).
    task automatic build_expected(input int n, input int lv);
        byte unsigned mb [0:1023];
        int L, nb, last;
        logic [63:0] w, v;
        ev_t e;
        L  = (n == 0) ? 0 : 8 * (n - 1) + lv;
        nb = L / RB + 1;
        for (int i = 0; i < nb * RB; i++) mb[i] = 8'h00;
        for (int i = 0; i < L; i++) begin
            w = words_a[i / 8];
            mb[i] = w[8 * (i % 8) +: 8];
        end
        mb[L] = mb[L] ^ 8'h06;
        mb[nb * RB - 1] = mb[nb * RB - 1] ^ 8'h80;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            last = (b < nb - 1) ? RL - 1 : (L - b * RB) / 8;
            for (int l = 0; l < RL; l++) begin
                if (l <= last || l == RL - 1) begin
                    for (int k = 0; k < 8; k++) v[8 * k +: 8] = mb[b * RB + l * 8 + k];
                    e.kind = 0; e.idx = l; e.data = v;
                    exp_q.push_back(e);
                end
            end
            e.kind = 1; e.idx = 0; e.data = '0;
            exp_q.push_back(e);
        end
        e.kind = 2; e.idx = 0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int idx, input logic [63:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d idx %0d data %h, expected none", kind, idx, data);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            if (e.kind == 0 && kind == 0) begin
                check("lane_idx", 64'(idx), 64'(e.idx));
                check("lane_data", data, e.data);
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #2;
        if (rst) begin
            perm_done  = 1'b0;
            fifo_empty = 1'b1;
            rd_req     = 1'b0;
        end else begin
            if (rd_req) begin
                if (fifo_q.size() > 0) begin
                    fifo_out = fifo_q.pop_front();
                    rd_cnt++;
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL fifo_overread: got read with %0d words left, expected none", fifo_q.size());
                end
                rd_req = 1'b0;
            end
            if (hold_cnt > 0) hold_cnt--;
            fifo_empty = (fifo_q.size() == 0) || (hold_cnt > 0) ||
                         (rand_empty && $urandom_range(0, 3) == 0);
            perm_done = 1'b0;
            if (perm_delay > 0) begin
                perm_delay--;
                if (perm_delay == 0) perm_done = 1'b1;
            end else if (spur_en && !perm_start && $urandom_range(0, 15) == 0) begin
                perm_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        ev_t le;
        if (!rst) begin
            rd_req = fifo_rd;
            if (fifo_empty) check("rd_while_empty", 64'(fifo_rd), 64'd0);
            if (lane_we) begin
                if (first_we < 0) first_we = cyc;
                le.kind = 0; le.idx = int'(lane_idx); le.data = lane_data;
                log_q.push_back(le);
                expect_ev(0, int'(lane_idx), lane_data);
            end
            if (perm_start) begin
                perm_cnt++;
                perm_delay = $urandom_range(1, 4);
                expect_ev(1, 0, '0);
            end
            if (done) expect_ev(2, 0, '0);
        end
    end

    task automatic recover();
        rst = 1'b1;
        exp_q.delete();
        fifo_q.delete();
        perm_delay = 0;
        hold_cnt = 0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_log(input string name, input int i, input int idx, input logic [63:0] data);
        if (i >= log_q.size()) begin
            tests++;
            fails++;
            $display("FAIL %s: got %0d writes, expected write #%0d", name, log_q.size(), i);
        end else begin
            check({name, "_idx"}, 64'(log_q[i].idx), 64'(idx));
            check({name, "_data"}, log_q[i].data, data);
        end
    endtask

    task automatic run_msg(input int n, input int lv, input bit spur_start, input int hold);
        bit finished;
        build_expected(n, lv);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(words_a[i]);
        log_q.delete();
        perm_cnt = 0;
        rd_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        msg_words = 16'(n);
        last_valid = 4'(lv);
        first_we = -1;
        t_start = cyc;
        hold_cnt = hold;
        @(negedge clk);
        start = 1'b0;
        msg_words = 16'($urandom);
        last_valid = 4'($urandom_range(1, 8));
        check("busy_after_start", 64'(busy), 64'd1);
        finished = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (spur_start && busy && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                msg_words = 16'($urandom_range(0, 40));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!finished) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done for n=%0d lv=%0d, expected done", n, lv);
            recover();
        end else begin
            @(negedge clk);
            check("busy_after_done", 64'(busy), 64'd0);
            check("done_one_cycle", 64'(done), 64'd0);
            check("events_left", 64'(exp_q.size()), 64'd0);
            check("fifo_reads", 64'(rd_cnt), 64'(n));
        end
        $display("[TB] msg n=%0d lv=%0d writes=%0d perms=%0d reads=%0d", n, lv, log_q.size(), perm_cnt, rd_cnt);
    endtask

    initial begin
        bit seen;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
        check("rst_lane_we", 64'(lane_we), 64'd0);
        check("rst_lane_idx", 64'(lane_idx), 64'd0);
        check("rst_lane_data", lane_data, 64'd0);
        check("rst_perm_start", 64'(perm_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Empty message
        run_msg(0, 8, 1'b0, 0);
        check("empty_nwrites", 64'(log_q.size()), 64'd2);
        chk_log("empty_w0", 0, 0, 64'h0000000000000006);
        chk_log("empty_w1", 1, 16, 64'h8000000000000000);
        check("empty_perms", 64'(perm_cnt), 64'd1);

        // One partial word; also pins start-to-first-write latency
        words_a[0] = 64'h1122334455667788;
        run_msg(1, 3, 1'b0, 0);
        check("latency_first_we", 64'(first_we), 64'(t_start + 2));
        chk_log("one_w0", 0, 0, 64'h0000000006667788);
        chk_log("one_w1", 1, 16, 64'h8000000000000000);
        check("one_perms", 64'(perm_cnt), 64'd1);

        // Exactly one full block of full words: padding spills into a second block
        for (int i = 0; i < 64; i++) words_a[i] = {$urandom, $urandom};
        run_msg(17, 8, 1'b0, 0);
        check("blk_nwrites", 64'(log_q.size()), 64'd19);
        chk_log("blk_w5", 5, 5, words_a[5]);
        chk_log("blk_w17", 17, 0, 64'h0000000000000006);
        chk_log("blk_w18", 18, 16, 64'h8000000000000000);
        check("blk_perms", 64'(perm_cnt), 64'd2);

        // Partial word in the top lane carries both pad bytes
        words_a[16] = 64'hFFFFFFFFFFFFFFFF;
        run_msg(17, 7, 1'b0, 0);
        check("top_nwrites", 64'(log_q.size()), 64'd17);
        chk_log("top_w16", 16, 16, 64'h86FFFFFFFFFFFFFF);
        check("top_perms", 64'(perm_cnt), 64'd1);

        // FIFO empty for 5 FETCH cycles before the first word
        run_msg(4, 8, 1'b0, 6);
        check("stall_first_we", 64'(first_we), 64'(t_start + 7));
        chk_log("stall_w1", 1, 1, words_a[1]);

        // Reset during the load of word 5
        build_expected(10, 8);
        fifo_q.delete();
        for (int i = 0; i < 10; i++) fifo_q.push_back(words_a[i]);
        @(negedge clk);
        start = 1'b1;
        msg_words = 16'd10;
        last_valid = 4'd8;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (lane_we && lane_idx == 5'd5) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_word5", 64'(seen), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_lane_we", 64'(lane_we), 64'd0);
        check("mid_rst_lane_data", lane_data, 64'd0);
        check("mid_rst_fifo_rd", 64'(fifo_rd), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_perm_start", 64'(perm_start), 64'd0);
        exp_q.delete();
        fifo_q.delete();
        perm_delay = 0;
        hold_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        words_a[0] = {$urandom, $urandom};
        run_msg(1, 5, 1'b0, 0);
        check("restart_nwrites", 64'(log_q.size()), 64'd2);
        chk_log("restart_w0", 0, 0, (words_a[0] & 64'h000000FFFFFFFFFF) | 64'h0000060000000000);

        // Randomized messages with FIFO gaps, ignored start pulses and stray perm_done
        rand_empty = 1'b1;
        spur_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int n, sel, lv;
            sel = $urandom_range(0, 6);
            case (sel)
                0: n = 0;
                1: n = 16;
                2: n = 17;
                3: n = 18;
                4: n = 34;
                default: n = $urandom_range(1, 45);
            endcase
            lv = $urandom_range(1, 8);
            for (int i = 0; i < 64; i++) words_a[i] = {$urandom, $urandom};
            run_msg(n, lv, 1'b1, 0);
        end
        rand_empty = 1'b0;
        spur_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sha3_absorb_ctrl.md
# sha3_absorb_ctrl

Absorb-phase sequencer sitting between the 64-bit message FIFO and the Keccak state/permutation core. It drains message words from the FIFO, XOR-writes them lane by lane into the rate portion of the state, and applies SHA-3 padding (0x06 … 0x80). It starts one permutation per full rate block and reports completion once the final padded block has been permuted.

## Interface
- WIDTH, 64, lane/FIFO word width (fixed 64; other values unsupported)
- RATE_LANES, 17, lanes per rate block (17 = SHA3-256; legal 9..21)
- LEN_W, 16, width of message word count
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a message; sampled only in IDLE
- msg_words  in  LEN_W  number of FIFO words in message incl. partial last word; latched on accepted start
- last_valid  in  4  valid bytes in final word, 1..8; latched on start; ignored when msg_words==0
- fifo_out  in  WIDTH  FIFO read data, valid the cycle after fifo_rd
- fifo_empty  in  1  FIFO empty flag
- fifo_rd  out  1  FIFO read strobe (combinational)
- lane_we  out  1  XOR lane_data into state lane lane_idx this cycle
- lane_idx  out  5  target lane, 0..RATE_LANES-1
- lane_data  out  WIDTH  value to XOR into lane
- perm_start  out  1  one-cycle pulse to start permutation
- perm_done  in  1  one-cycle pulse from permutation core
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after final permutation completes

## Operation
- States: IDLE, FETCH, LOAD, PAD, FINAL, PERM, DONE.
- IDLE: on start, latch msg_words/last_valid, clear word counter and lane counter; go FETCH (msg_words>0) or PAD (msg_words==0).
- FETCH: fifo_rd = !fifo_empty; on read go LOAD, else hold. No other state asserts fifo_rd.
- LOAD: lane_we=1, lane_idx=lane counter, lane_data=fifo_out; increment word counter.
  - Final word with last_valid<8: bytes ≥last_valid zeroed, OR 0x06<<(8*last_valid); if lane==RATE_LANES-1 also OR 0x80<<56 (final block).
- Little-endian byte order: byte k occupies bits [8k+7:8k].
- PAD (message ended on word boundary, or empty message): lane_data=0x06, OR 0x80<<56 if lane==RATE_LANES-1.
- FINAL: lane_idx=RATE_LANES-1, lane_data=0x80<<56; entered when pad byte landed in a lane < RATE_LANES-1.
- After any write to lane RATE_LANES-1 → PERM; otherwise lane counter +1 and go to FETCH (more words), PAD (last full word written) or FINAL (pad byte written).
- PERM: perm_start pulses on entry cycle only; wait for perm_done; lane counter → 0; then FETCH, PAD (last word was full and filled the block), or DONE (block contained 0x80).
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE ignored; perm_done outside PERM ignored.

## Timing
- Reset (async assert): state IDLE, counters 0, all outputs 0 (fifo_rd, lane_we, lane_idx, lane_data, perm_start, busy, done).
- Reset mid-message returns to IDLE immediately; no further FIFO reads; partial block is abandoned (state clearing is the core's job).
- fifo_rd is the only output depending combinationally on fifo_empty; lane_data depends combinationally on fifo_out in LOAD only; all others decoded from registers.
- Steady state: 2 cycles per word (FETCH, LOAD) when FIFO never empty; each empty cycle in FETCH adds one cycle.
- start at cycle T (IDLE) → FETCH at T+1 → first lane_we at T+2 (FIFO non-empty).
- PERM: perm_start at entry cycle P; the state holds until perm_done; next state at cycle after perm_done.
- done asserts the cycle after the final perm_done; busy drops with done's falling edge (busy low in DONE+1).

## Test plan
- Empty message (msg_words=0): lane0 ← 0x0000000000000006, lane16 ← 0x8000000000000000, one perm_start, done; no fifo_rd.
- msg_words=1, last_valid=3, word 0x1122334455667788: lane0 ← 0x0000000006667788, lane16 ← 0x8000000000000000, one permutation, done.
- msg_words=17, last_valid=8: lanes 0..16 get raw words, perm; second block lane0 ← 0x06, lane16 ← 0x80<<56, second perm, done (two perm_start total).
- msg_words=17, last_valid=7, word16=0xFFFFFFFFFFFFFFFF: lane16 ← 0x86FFFFFFFFFFFFFF, exactly one permutation, no FINAL write.
- FIFO empty stalls: fifo_empty high 5 cycles in FETCH → fifo_rd low, no lane_we during stall, then data resumes with correct lane_idx.
- Reset asserted during LOAD of word 5 → all outputs 0 same cycle, IDLE; subsequent start with msg_words=1 restarts at lane0.
